// File: rtl/fifo_chk_pkg.sv
// Shared definitions for the FIFO reference checker.
// Holds the default parameter values and the bit positions used in the
// per-field mismatch vector.
package fifo_chk_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

  localparam int MM_BITS        = 8;
  localparam int MM_DATA_OUT    = 0;
  localparam int MM_WR_ACK      = 1;
  localparam int MM_OVERFLOW    = 2;
  localparam int MM_UNDERFLOW   = 3;
  localparam int MM_FULL        = 4;
  localparam int MM_EMPTY       = 5;
  localparam int MM_ALMOSTFULL  = 6;
  localparam int MM_ALMOSTEMPTY = 7;

  typedef logic [MM_BITS-1:0] mm_vec_t;

endpackage

// File: rtl/fifo_ref_checker_if.sv
// Observed-FIFO bundle: the inputs applied to the FIFO under observation and
// the outputs it produced.
//   master : side that drives the FIFO stimulus and its responses
//   slave  : checker side, samples everything
interface fifo_ref_checker_if
  import fifo_chk_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
);
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;

  modport master (
    output data_in, wr_en, rd_en, data_out, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty
  );

  modport slave (
    input  data_in, wr_en, rd_en, data_out, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty
  );
endinterface

// File: rtl/fifo_ref_model.sv
// Cycle-accurate reference FIFO. Tracks the observed FIFO's inputs and
// produces the outputs a correct FIFO would show after each edge.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   data_in, wr_en, rd_en  observed FIFO inputs
//   *_exp                  expected FIFO outputs (registered / from count)
//   read_seen              model has popped at least one entry since reset
module fifo_ref_model
  import fifo_chk_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out_exp,
  output logic                  wr_ack_exp,
  output logic                  overflow_exp,
  output logic                  underflow_exp,
  output logic                  full_exp,
  output logic                  empty_exp,
  output logic                  almostfull_exp,
  output logic                  almostempty_exp,
  output logic                  read_seen
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  do_wr;
  logic                  do_rd;

  assign full_exp        = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign almostfull_exp  = (count == (PTR_W+1)'(FIFO_DEPTH - 1));
  assign empty_exp       = (count == '0);
  assign almostempty_exp = (count == (PTR_W+1)'(1));

  // Full blocks the write and empty blocks the read, which yields the
  // read-only / write-only behaviour for simultaneous requests.
  assign do_wr = wr_en && !full_exp;
  assign do_rd = rd_en && !empty_exp;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_out_exp  <= '0;
      wr_ack_exp    <= 1'b0;
      overflow_exp  <= 1'b0;
      underflow_exp <= 1'b0;
      read_seen     <= 1'b0;
    end else begin
      wr_ack_exp    <= do_wr;
      overflow_exp  <= wr_en && full_exp;
      underflow_exp <= rd_en && empty_exp;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr       <= rd_ptr + 1'b1;
        data_out_exp <= mem[rd_ptr];
        read_seen    <= 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fifo_ref_checker.sv
// Scoreboard for an observed FIFO: compares its outputs against the
// fifo_ref_model prediction and keeps pass/fail statistics.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   chk_en           enables comparison (model keeps tracking regardless)
//   obs              observed FIFO inputs/outputs (slave modport)
//   test_finished    freezes results and raises done
//   error_count      saturating count of cycles with a mismatch
//   correct_count    saturating count of clean check cycles
//   mismatch(_vec)   registered per-field compare result of the last edge
//   first_err_vec    first nonzero mismatch vector since reset
//   first_err_cycle  cycle number at which that mismatch was seen
//   done, pass       end-of-test status
module fifo_ref_checker
  import fifo_chk_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chk_en,
  fifo_ref_checker_if.slave    obs,
  input  logic                 test_finished,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] correct_count,
  output logic                 mismatch,
  output mm_vec_t              mismatch_vec,
  output mm_vec_t              first_err_vec,
  output logic [31:0]          first_err_cycle,
  output logic                 done,
  output logic                 pass
);
  logic [FIFO_WIDTH-1:0] data_out_exp;
  logic wr_ack_exp, overflow_exp, underflow_exp;
  logic full_exp, empty_exp, almostfull_exp, almostempty_exp;
  logic read_seen;

  fifo_ref_model #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_model (
    .clk             (clk),
    .rst             (rst),
    .data_in         (obs.data_in),
    .wr_en           (obs.wr_en),
    .rd_en           (obs.rd_en),
    .data_out_exp    (data_out_exp),
    .wr_ack_exp      (wr_ack_exp),
    .overflow_exp    (overflow_exp),
    .underflow_exp   (underflow_exp),
    .full_exp        (full_exp),
    .empty_exp       (empty_exp),
    .almostfull_exp  (almostfull_exp),
    .almostempty_exp (almostempty_exp),
    .read_seen       (read_seen)
  );

  mm_vec_t     cmp_vec;
  logic        check_armed;
  logic        check_cyc;
  logic        first_err_seen;
  logic [31:0] cycle_cnt;

  // data_out is meaningless until the model has popped something.
  always_comb begin
    cmp_vec                 = '0;
    cmp_vec[MM_DATA_OUT]    = read_seen && (obs.data_out != data_out_exp);
    cmp_vec[MM_WR_ACK]      = obs.wr_ack      != wr_ack_exp;
    cmp_vec[MM_OVERFLOW]    = obs.overflow    != overflow_exp;
    cmp_vec[MM_UNDERFLOW]   = obs.underflow   != underflow_exp;
    cmp_vec[MM_FULL]        = obs.full        != full_exp;
    cmp_vec[MM_EMPTY]       = obs.empty       != empty_exp;
    cmp_vec[MM_ALMOSTFULL]  = obs.almostfull  != almostfull_exp;
    cmp_vec[MM_ALMOSTEMPTY] = obs.almostempty != almostempty_exp;
  end

  assign check_cyc = chk_en && check_armed && !done;
  assign pass      = done && (error_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      error_count     <= '0;
      correct_count   <= '0;
      mismatch        <= 1'b0;
      mismatch_vec    <= '0;
      first_err_vec   <= '0;
      first_err_cycle <= '0;
      first_err_seen  <= 1'b0;
      cycle_cnt       <= '0;
      check_armed     <= 1'b0;
      done            <= 1'b0;
    end else begin
      cycle_cnt    <= cycle_cnt + 1'b1;
      check_armed  <= 1'b1;
      mismatch_vec <= check_cyc ? cmp_vec : '0;
      mismatch     <= check_cyc && (|cmp_vec);
      if (check_cyc) begin
        if (|cmp_vec) begin
          if (error_count != '1) error_count <= error_count + 1'b1;
          if (!first_err_seen) begin
            first_err_seen  <= 1'b1;
            first_err_vec   <= cmp_vec;
            first_err_cycle <= cycle_cnt;
          end
        end else if (correct_count != '1) begin
          correct_count <= correct_count + 1'b1;
        end
      end
      if (test_finished) done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_ref_checker.sv
module tb_fifo_ref_checker;
  import fifo_chk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, chk_en, test_finished, wr_en, rd_en;
  logic [15:0] data_in;

  // lane 0: depth 8, 16-bit counters; lane 1: depth 4, 4-bit counters
  int depth[2];
  int cmax[2];

  logic [15:0] obs_dout[2];
  logic        obs_ack[2], obs_ovf[2], obs_udf[2], obs_full[2];
  logic        obs_empty[2], obs_af[2], obs_ae[2];
  logic [7:0]  flip[2];

  logic [15:0] gq[2][$];
  logic [15:0] g_dout[2];
  logic        g_ack[2], g_ovf[2], g_udf[2], g_rs[2];

  logic        r_armed[2], r_done[2];
  int          r_err[2], r_corr[2], r_cyc[2], r_fec[2];
  logic [7:0]  r_fev[2], r_mv[2];

  logic [15:0] err0, corr0;
  logic [3:0]  err1, corr1;
  logic [7:0]  mv_o[2], fev_o[2];
  logic [31:0] fec_o[2];
  logic        mm_o[2], dn_o[2], ps_o[2];

  int checks = 0;
  int failures = 0;

  fifo_ref_checker_if #(.FIFO_WIDTH(16)) if0 ();
  fifo_ref_checker_if #(.FIFO_WIDTH(16)) if1 ();

  assign if0.data_in = data_in;       assign if1.data_in = data_in;
  assign if0.wr_en = wr_en;           assign if1.wr_en = wr_en;
  assign if0.rd_en = rd_en;           assign if1.rd_en = rd_en;
  assign if0.data_out = obs_dout[0];  assign if1.data_out = obs_dout[1];
  assign if0.wr_ack = obs_ack[0];     assign if1.wr_ack = obs_ack[1];
  assign if0.overflow = obs_ovf[0];   assign if1.overflow = obs_ovf[1];
  assign if0.underflow = obs_udf[0];  assign if1.underflow = obs_udf[1];
  assign if0.full = obs_full[0];      assign if1.full = obs_full[1];
  assign if0.empty = obs_empty[0];    assign if1.empty = obs_empty[1];
  assign if0.almostfull = obs_af[0];  assign if1.almostfull = obs_af[1];
  assign if0.almostempty = obs_ae[0]; assign if1.almostempty = obs_ae[1];

  fifo_ref_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .chk_en(chk_en), .obs(if0), .test_finished(test_finished),
    .error_count(err0), .correct_count(corr0), .mismatch(mm_o[0]), .mismatch_vec(mv_o[0]),
    .first_err_vec(fev_o[0]), .first_err_cycle(fec_o[0]), .done(dn_o[0]), .pass(ps_o[0]));

  fifo_ref_checker #(.FIFO_WIDTH(16), .FIFO_DEPTH(4), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .chk_en(chk_en), .obs(if1), .test_finished(test_finished),
    .error_count(err1), .correct_count(corr1), .mismatch(mm_o[1]), .mismatch_vec(mv_o[1]),
    .first_err_vec(fev_o[1]), .first_err_cycle(fec_o[1]), .done(dn_o[1]), .pass(ps_o[1]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Observed FIFO = ideal queue FIFO with selected fields corrupted by flip.
  task automatic drive_obs();
    for (int l = 0; l < 2; l++) begin
      int sz = gq[l].size();
      obs_dout[l]  = g_dout[l] ^ {15'd0, flip[l][MM_DATA_OUT]};
      obs_ack[l]   = g_ack[l] ^ flip[l][MM_WR_ACK];
      obs_ovf[l]   = g_ovf[l] ^ flip[l][MM_OVERFLOW];
      obs_udf[l]   = g_udf[l] ^ flip[l][MM_UNDERFLOW];
      obs_full[l]  = (sz == depth[l]) ^ flip[l][MM_FULL];
      obs_empty[l] = (sz == 0) ^ flip[l][MM_EMPTY];
      obs_af[l]    = (sz == depth[l] - 1) ^ flip[l][MM_ALMOSTFULL];
      obs_ae[l]    = (sz == 1) ^ flip[l][MM_ALMOSTEMPTY];
    end
  endtask

  task automatic model_update(input int l);
    int sz;
    logic [7:0] mv;
    logic gfull, gempty, dw, dr, chk_cyc;
    if (rst) begin
      gq[l].delete();
      g_dout[l] = '0; g_ack[l] = 0; g_ovf[l] = 0; g_udf[l] = 0; g_rs[l] = 0;
      r_armed[l] = 0; r_done[l] = 0; r_err[l] = 0; r_corr[l] = 0;
      r_cyc[l] = 0; r_fec[l] = 0; r_fev[l] = '0; r_mv[l] = '0;
      return;
    end
    sz = gq[l].size();
    mv = '0;
    mv[MM_DATA_OUT]    = g_rs[l] && (obs_dout[l] != g_dout[l]);
    mv[MM_WR_ACK]      = obs_ack[l] != g_ack[l];
    mv[MM_OVERFLOW]    = obs_ovf[l] != g_ovf[l];
    mv[MM_UNDERFLOW]   = obs_udf[l] != g_udf[l];
    mv[MM_FULL]        = obs_full[l] != (sz == depth[l]);
    mv[MM_EMPTY]       = obs_empty[l] != (sz == 0);
    mv[MM_ALMOSTFULL]  = obs_af[l] != (sz == depth[l] - 1);
    mv[MM_ALMOSTEMPTY] = obs_ae[l] != (sz == 1);
    chk_cyc = chk_en && r_armed[l] && !r_done[l];
    r_mv[l] = chk_cyc ? mv : 8'h00;
    if (chk_cyc) begin
      if (mv != 0) begin
        if (r_err[l] < cmax[l]) r_err[l]++;
        if (r_fev[l] == 0) begin r_fev[l] = mv; r_fec[l] = r_cyc[l]; end
      end else if (r_corr[l] < cmax[l]) r_corr[l]++;
    end
    r_cyc[l]++;
    r_armed[l] = 1;
    if (test_finished) r_done[l] = 1;
    gfull = (sz == depth[l]);
    gempty = (sz == 0);
    dw = wr_en && !gfull;
    dr = rd_en && !gempty;
    g_ack[l] = dw;
    g_ovf[l] = wr_en && gfull;
    g_udf[l] = rd_en && gempty;
    if (dr) begin g_dout[l] = gq[l].pop_front(); g_rs[l] = 1; end
    if (dw) gq[l].push_back(data_in);
  endtask

  task automatic check_lane(input int l);
    logic [31:0] ge, gc;
    ge = (l == 0) ? 32'(err0) : 32'(err1);
    gc = (l == 0) ? 32'(corr0) : 32'(corr1);
    chk($sformatf("l%0d error_count", l), ge, r_err[l]);
    chk($sformatf("l%0d correct_count", l), gc, r_corr[l]);
    chk($sformatf("l%0d mismatch_vec", l), {24'd0, mv_o[l]}, {24'd0, r_mv[l]});
    chk($sformatf("l%0d mismatch", l), {31'd0, mm_o[l]}, {31'd0, (r_mv[l] != 0)});
    chk($sformatf("l%0d first_err_vec", l), {24'd0, fev_o[l]}, {24'd0, r_fev[l]});
    chk($sformatf("l%0d first_err_cycle", l), fec_o[l], r_fec[l]);
    chk($sformatf("l%0d done", l), {31'd0, dn_o[l]}, {31'd0, r_done[l]});
    chk($sformatf("l%0d pass", l), {31'd0, ps_o[l]}, {31'd0, (r_done[l] && r_err[l] == 0)});
  endtask

  task automatic tick();
    drive_obs();
    @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) model_update(l);
    drive_obs();
    for (int l = 0; l < 2; l++) check_lane(l);
  endtask

  task automatic idle_in();
    wr_en = 0; rd_en = 0; test_finished = 0; chk_en = 1;
    flip[0] = '0; flip[1] = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1; tick(); tick();
    rst = 0;
  endtask

  typedef struct {
    logic        wr, rd;
    logic [15:0] d;
    logic [7:0]  flp, e_mv, e_fev;
    int          e_err, e_corr, e_fec;
  } vec_t;
  vec_t tbl[22];

  function automatic vec_t mk(logic wr, logic rd, logic [15:0] d, logic [7:0] flp,
                              logic [7:0] e_mv, int e_err, int e_corr,
                              logic [7:0] e_fev, int e_fec);
    vec_t v;
    v.wr = wr; v.rd = rd; v.d = d; v.flp = flp; v.e_mv = e_mv;
    v.e_err = e_err; v.e_corr = e_corr; v.e_fev = e_fev; v.e_fec = e_fec;
    return v;
  endfunction

  bit is_wr[10] = '{1, 1, 1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    depth[0] = 8; depth[1] = 4;
    cmax[0] = 65535; cmax[1] = 15;
    for (int l = 0; l < 2; l++) begin
      g_dout[l] = '0; g_ack[l] = 0; g_ovf[l] = 0; g_udf[l] = 0; g_rs[l] = 0;
      r_armed[l] = 0; r_done[l] = 0; r_err[l] = 0; r_corr[l] = 0;
      r_cyc[l] = 0; r_fec[l] = 0; r_fev[l] = '0; r_mv[l] = '0;
    end
    data_in = '0;

    // lane 0 after reset: fill to full, overflow with a forced-low
    // overflow flag, then drain and underflow
    tbl[0] = mk(1, 0, 16'h0001, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    for (int i = 1; i < 8; i++)
      tbl[i] = mk(1, 0, 16'(i + 1), 8'h00, 8'h00, 0, i, 8'h00, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 8, 8'h00, 0);
    tbl[9]  = mk(1, 0, 16'h0099, 8'h00, 8'h00, 0, 9, 8'h00, 0);
    tbl[10] = mk(0, 0, 16'h0000, 8'h04, 8'h04, 1, 9, 8'h04, 10);
    tbl[11] = mk(0, 0, 16'h0000, 8'h00, 8'h00, 1, 10, 8'h04, 10);
    for (int i = 12; i < 20; i++)
      tbl[i] = mk(0, 1, 16'h0000, 8'h00, 8'h00, 1, i - 1, 8'h04, 10);
    tbl[20] = mk(0, 1, 16'h0000, 8'h00, 8'h00, 1, 19, 8'h04, 10);
    tbl[21] = mk(0, 0, 16'h0000, 8'h00, 8'h00, 1, 20, 8'h04, 10);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      wr_en = tbl[i].wr; rd_en = tbl[i].rd; data_in = tbl[i].d;
      flip[0] = tbl[i].flp; flip[1] = '0;
      tick();
      chk($sformatf("tbl%0d mismatch_vec", i), {24'd0, mv_o[0]}, {24'd0, tbl[i].e_mv});
      chk($sformatf("tbl%0d error_count", i), 32'(err0), tbl[i].e_err);
      chk($sformatf("tbl%0d correct_count", i), 32'(corr0), tbl[i].e_corr);
      chk($sformatf("tbl%0d first_err_vec", i), {24'd0, fev_o[0]}, {24'd0, tbl[i].e_fev});
      chk($sformatf("tbl%0d first_err_cycle", i), fec_o[0], tbl[i].e_fec);
    end

    // data_out is ignored before the first real pop; an underflowing read
    // does not count as a pop
    do_reset();
    tick();
    flip[0] = 8'h01; tick();
    flip[0] = 8'h00; rd_en = 1; tick();
    rd_en = 0; tick();
    flip[0] = 8'h01; tick();
    chk("noread error_count", 32'(err0), 0);
    chk("noread mismatch_vec", {24'd0, mv_o[0]}, 0);
    chk("noread correct_count", 32'(corr0), 4);

    // depth-4 lane: interleaved traffic across pointer wrap, third read corrupted
    do_reset();
    tick();
    for (int i = 0; i < 10; i++) begin
      wr_en = is_wr[i]; rd_en = !is_wr[i]; data_in = 16'(16'hA0 + i);
      flip[1] = (i == 8) ? 8'h01 : 8'h00;
      tick();
      if (i == 8) begin
        chk("wrap mismatch_vec", {24'd0, mv_o[1]}, 32'h01);
        chk("wrap mismatch", {31'd0, mm_o[1]}, 1);
      end
    end
    idle_in();

    // 4-bit counter saturation and freeze after test_finished
    flip[1] = 8'h10;
    for (int i = 0; i < 20; i++) tick();
    chk("sat error_count", 32'(err1), 32'hF);
    test_finished = 1; tick();
    test_finished = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("sat done", {31'd0, dn_o[1]}, 1);
    chk("sat pass", {31'd0, ps_o[1]}, 0);
    chk("sat frozen error_count", 32'(err1), 32'hF);
    chk("sat frozen mismatch_vec", {24'd0, mv_o[1]}, 0);

    // reset in the middle of a stream holding 5 entries
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; data_in = 16'(16'h50 + i); tick();
    end
    idle_in();
    flip[0] = 8'h02; tick();
    rst = 1; tick();
    chk("rst error_count", 32'(err0), 0);
    chk("rst correct_count", 32'(corr0), 0);
    chk("rst mismatch_vec", {24'd0, mv_o[0]}, 0);
    chk("rst first_err_vec", {24'd0, fev_o[0]}, 0);
    chk("rst first_err_cycle", fec_o[0], 0);
    chk("rst done", {31'd0, dn_o[0]}, 0);
    rst = 0; flip[0] = 8'h00; tick();
    flip[0] = 8'h20; tick();
    chk("post-rst empty expected", {24'd0, mv_o[0]}, 32'h20);
    idle_in();

    // random traffic with occasional faults, resets and pauses
    do_reset();
    for (int i = 0; i < 600; i++) begin
      wr_en = ($urandom_range(0, 99) < 55);
      rd_en = ($urandom_range(0, 99) < 50);
      data_in = 16'($urandom);
      chk_en = ($urandom_range(0, 9) != 0);
      test_finished = ($urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 149) == 0);
      for (int l = 0; l < 2; l++)
        flip[l] = ($urandom_range(0, 24) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      tick();
    end
    rst = 0;

    // clean run must end in pass on both lanes
    do_reset();
    for (int i = 0; i < 80; i++) begin
      wr_en = ($urandom_range(0, 1) == 1);
      rd_en = ($urandom_range(0, 1) == 1);
      data_in = 16'($urandom);
      tick();
    end
    idle_in();
    test_finished = 1; tick();
    test_finished = 0; tick();
    chk("clean pass lane0", {31'd0, ps_o[0]}, 1);
    chk("clean pass lane1", {31'd0, ps_o[1]}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_ref_checker.md
FIFO_REF_CHECKER -- requirements
Module: fifo_ref_checker

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, the observed data width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, the observed FIFO depth (>=4, power of two).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, the width of the error and correct counters.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 Ports SHALL be: chk_en in 1 check enable; data_in in FIFO_WIDTH; wr_en in 1; rd_en in 1 (observed FIFO inputs).
REQ-006 Ports SHALL be: data_out in FIFO_WIDTH; wr_ack, overflow, underflow, full, empty, almostfull, almostempty in 1 each (observed FIFO outputs).
REQ-007 Ports SHALL be: test_finished in 1 end-of-test request; error_count out CNT_WIDTH; correct_count out CNT_WIDTH.
REQ-008 Ports SHALL be: mismatch out 1 per-cycle error pulse; mismatch_vec out 8 per-field error bits; first_err_vec out 8; first_err_cycle out 32; done out 1; pass out 1.

Function
REQ-009 Internal reference model SHALL update on each rising clk from data_in/wr_en/rd_en and hold its outputs in registers, matching the observed FIFO's registered timing.
REQ-010 Model write SHALL occur when wr_en && !full_exp; wr_ack_exp=1 next cycle, else 0; overflow_exp=1 next cycle iff wr_en && full_exp.
REQ-011 Model read SHALL occur when rd_en && !empty_exp; data_out_exp loads the oldest entry next cycle, else holds; underflow_exp=1 next cycle iff rd_en && empty_exp.
REQ-012 Simultaneous wr_en and rd_en: full -> read only; empty -> write only; otherwise both, count unchanged.
REQ-013 Model flags SHALL derive from count: full=count==FIFO_DEPTH, almostfull=count==FIFO_DEPTH-1, empty=count==0, almostempty=count==1.
REQ-014 Pointers SHALL be log2(FIFO_DEPTH) bits and wrap from FIFO_DEPTH-1 to 0; count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-015 A check cycle SHALL be any rising edge with chk_en=1, check_armed=1 and done=0; check_armed sets 1 the first edge after rst deasserts.
REQ-016 On a check cycle each observed output SHALL be compared with its model counterpart; mismatch_vec bit order: 0 data_out, 1 wr_ack, 2 overflow, 3 underflow, 4 full, 5 empty, 6 almostfull, 7 almostempty.
REQ-017 data_out SHALL be compared only after the model has performed at least one read since reset; before that bit 0 is forced 0.
REQ-018 mismatch_vec and mismatch (OR of vec) SHALL be registered: valid one cycle after the compared edge, zero on non-check cycles.
REQ-019 Per check cycle exactly one of error_count/correct_count SHALL increment by 1; both saturate at all-ones.
REQ-020 first_err_vec/first_err_cycle SHALL capture the first nonzero mismatch_vec and its free-running cycle number since reset, then hold until reset.
REQ-021 test_finished=1 on a rising edge SHALL set done=1 (sticky) next cycle; counters and first_err fields then freeze.
REQ-022 pass SHALL equal done && error_count==0.
REQ-023 chk_en=0 SHALL pause comparison only; the model keeps tracking inputs.

Reset
REQ-024 On rst=1: pointers, count, data_out_exp, error_count, correct_count, mismatch, mismatch_vec, first_err_vec, first_err_cycle, cycle counter, check_armed, done, pass SHALL be 0; empty_exp SHALL read 1.
REQ-025 Reset asserted mid-test SHALL discard all model contents and results; storage array needs no reset.

Structure
REQ-026 Shared package fifo_chk_pkg SHALL hold the mismatch bit-index localparams and default parameter values.
REQ-027 The reference model SHALL be sub-module fifo_ref_model; comparison, counters and reporting stay in fifo_ref_checker.

Verification
REQ-028 Reset then 8 writes 0x0001..0x0008 with correct DUT -> full=1 after 8th, correct_count=8, error_count=0.
REQ-029 Full FIFO, wr_en=1 one cycle, observed overflow forced 0 -> mismatch_vec=0x04, error_count=1, first_err_vec=0x04.
REQ-030 Empty FIFO, rd_en=1 -> underflow expected 1; observed 1 -> no error; observed data_out before any read ignored.
REQ-031 Depth 4, 10 interleaved writes/reads across pointer wrap, observed data_out corrupted on 3rd read -> mismatch_vec=0x01 one cycle after that data appears.
REQ-032 CNT_WIDTH=4, 20 error cycles -> error_count holds 0xF; test_finished=1 -> done=1, pass=0, counts frozen.
REQ-033 rst pulsed mid-stream with 5 entries -> all outputs per REQ-024 next cycle, first post-reset check expects empty=1.
